// File: rtl/seq_detect_1_if.sv
// -----------------------------------------------------------------------------
// seq_detect_1_if : serial input and result pulses of the seq_detect_1 checker.
// Optional macro SEQ_DETECT_1_STATS_EN adds the match/mismatch counters.
// -----------------------------------------------------------------------------
interface seq_detect_1_if;
    logic        data;
    logic        match;
    logic        not_match;
`ifdef SEQ_DETECT_1_STATS_EN
    logic [15:0] match_cnt;
    logic [15:0] mismatch_cnt;
`endif

`ifdef SEQ_DETECT_1_STATS_EN
    // Source of the serial stream, consumer of the results.
    modport master (
        output data,
        input  match,
        input  not_match,
        input  match_cnt,
        input  mismatch_cnt
    );

    // The checker itself.
    modport slave (
        input  data,
        output match,
        output not_match,
        output match_cnt,
        output mismatch_cnt
    );
`else
    // Source of the serial stream, consumer of the results.
    modport master (
        output data,
        input  match,
        input  not_match
    );

    // The checker itself.
    modport slave (
        input  data,
        output match,
        output not_match
    );
`endif
endinterface

// File: rtl/seq_detect_1.sv
// -----------------------------------------------------------------------------
// seq_detect_1 : non-overlapping fixed-length serial word checker.
// The input stream is cut into consecutive LEN-bit groups (first bit = MSB)
// starting at the first edge after reset release. Each completed group gives
// a one-cycle registered match or not_match pulse. There is no
// resynchronisation: a mismatch does not shift the group boundaries.
// Optional macro SEQ_DETECT_1_STATS_EN adds saturating 16-bit counters
// match_cnt / mismatch_cnt on the interface.
// -----------------------------------------------------------------------------
module seq_detect_1 #(
    parameter int             LEN     = 6,
    parameter logic [LEN-1:0] PATTERN = 6'b011100
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_detect_1_if.slave    bus
);

    localparam int CNT_W = $clog2(LEN);

    // Only the LEN-1 earlier bits need storing; the last bit is taken live.
    logic [CNT_W-1:0] cnt_r;
    logic [LEN-2:0]   sh_r;
    logic             match_r;
    logic             not_match_r;

    logic [LEN-1:0]   word_s;
    logic             last_s;
    logic             hit_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Assemble the current group and decide whether this edge closes it.
    always_comb begin
        word_s    = {sh_r, bus.data};
        last_s    = (cnt_r == CNT_W'(LEN - 1));
        hit_s     = (word_s == PATTERN);
        cnt_nxt_s = cnt_r;
        if (last_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Bit position, shift history and the registered result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            sh_r        <= {(LEN-1){1'b0}};
            match_r     <= 1'b0;
            not_match_r <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            sh_r        <= word_s[LEN-2:0];
            match_r     <= last_s & hit_s;
            not_match_r <= last_s & ~hit_s;
        end
    end

    assign bus.match     = match_r;
    assign bus.not_match = not_match_r;

`ifdef SEQ_DETECT_1_STATS_EN
    logic [15:0] match_cnt_r;
    logic [15:0] mismatch_cnt_r;

    // Saturating event counters, stepped on the same edge as their pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt_r    <= 16'h0000;
            mismatch_cnt_r <= 16'h0000;
        end else begin
            if (last_s && hit_s && (match_cnt_r != 16'hFFFF)) begin
                match_cnt_r <= match_cnt_r + 16'h0001;
            end else begin
                match_cnt_r <= match_cnt_r;
            end
            if (last_s && !hit_s && (mismatch_cnt_r != 16'hFFFF)) begin
                mismatch_cnt_r <= mismatch_cnt_r + 16'h0001;
            end else begin
                mismatch_cnt_r <= mismatch_cnt_r;
            end
        end
    end

    assign bus.match_cnt    = match_cnt_r;
    assign bus.mismatch_cnt = mismatch_cnt_r;
`endif

endmodule

// File: tb/tb_seq_detect_1.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_1 : directed plus randomized bench for seq_detect_1.
// Reference model: bits received since reset are collected in a queue; each
// time LEN bits have accumulated, their value (first bit most significant)
// is compared with PATTERN to predict the pulse on that same cycle.
// -----------------------------------------------------------------------------
module tb_seq_detect_1;

    localparam int             LEN = 6;
    localparam logic [LEN-1:0] PAT = 6'b011100;

    logic clk;
    logic rst_n;

    seq_detect_1_if bus ();

    seq_detect_1 #(
        .LEN     (LEN),
        .PATTERN (PAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    bit          grp[$];
    int unsigned m_hits;
    int unsigned m_miss;

    // Single comparison point: count it and report a mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Compare every observable output with the model's prediction.
    task automatic check_all(input string tag, input bit em, input bit enm);
        chk({tag, ".match"}, 32'(bus.match), 32'(em));
        chk({tag, ".not_match"}, 32'(bus.not_match), 32'(enm));
`ifdef SEQ_DETECT_1_STATS_EN
        chk({tag, ".match_cnt"}, 32'(bus.match_cnt), m_hits);
        chk({tag, ".mismatch_cnt"}, 32'(bus.mismatch_cnt), m_miss);
`endif
    endtask

    // Drive one bit, let one edge sample it, then check against the model.
    task automatic step(input bit b);
        int unsigned v;
        bit          em;
        bit          enm;
        bus.data = b;
        @(posedge clk);
        #1;
        grp.push_back(b);
        em  = 1'b0;
        enm = 1'b0;
        if (grp.size() == LEN) begin
            v = 0;
            foreach (grp[i]) v = v * 2 + int'(grp[i]);
            em  = (v == int'(PAT));
            enm = !em;
            if (em  && m_hits < 32'hFFFF) m_hits++;
            if (enm && m_miss < 32'hFFFF) m_miss++;
            grp.delete();
        end
        check_all("step", em, enm);
    endtask

    // Send one LEN-bit word, MSB first.
    task automatic send_word(input logic [LEN-1:0] w);
        for (int i = LEN - 1; i >= 0; i--) step(w[i]);
    endtask

    // Asynchronous reset taken between edges; outputs must clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        grp.delete();
        m_hits = 0;
        m_miss = 0;
        check_all("in_reset", 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_all("held_reset", 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        m_hits   = 0;
        m_miss   = 0;
        rst_n    = 1'b0;
        bus.data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_state", 1'b0, 1'b0);
        rst_n = 1'b1;

        // Matching group, then a back-to-back second match.
        send_word(6'b011100);
        send_word(6'b011100);
        // Differing group.
        send_word(6'b111100);
        // Idle zeros: three not_match pulses.
        for (int i = 0; i < 18; i++) step(1'b0);
        // Pattern shifted by one bit inside the group: not detected.
        send_word(6'b001110);
        send_word(6'b000000);

        // Reset after three bits discards the partial group.
        step(1'b0);
        step(1'b1);
        step(1'b1);
        do_reset();
        send_word(6'b011100);

        // Reset while a match pulse is high clears it immediately.
        send_word(6'b011100);
        do_reset();

`ifdef SEQ_DETECT_1_STATS_EN
        send_word(6'b011100);
        send_word(6'b011100);
        send_word(6'b010101);
        chk("stats_match_cnt", 32'(bus.match_cnt), 32'd2);
        chk("stats_mismatch_cnt", 32'(bus.mismatch_cnt), 32'd1);
        do_reset();
        chk("stats_match_clr", 32'(bus.match_cnt), 32'd0);
        chk("stats_mismatch_clr", 32'(bus.mismatch_cnt), 32'd0);
`endif

        // Randomized groups: half exact pattern, half random, rare resets.
        for (int g = 0; g < 60; g++) begin
            logic [LEN-1:0] w;
            int             cut;
            if ($urandom_range(0, 1) == 0) begin
                w = PAT;
            end else begin
                w = LEN'($urandom);
            end
            cut = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, LEN - 1)) : LEN;
            for (int i = LEN - 1; i >= LEN - cut; i--) step(w[i]);
            if (cut != LEN) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_1.md
Name: seq_detect_1

Overview:
- Serial, non-overlapping, fixed-length sequence checker.
- After reset release it splits the 1-bit input stream into consecutive groups of LEN bits and compares each group against PATTERN.
- Each completed group produces a single-cycle match or not_match pulse.
- Sits after a serial receiver / bit slicer as a frame-word checker.

Parameters:
- LEN, 6, group length in bits (legal range 2..32).
- PATTERN, 6'b011100, reference word. MSB = first bit received in a group.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- data  in  1  serial input bit, sampled on every rising clk edge while rst_n=1
- match  out  1  one-cycle pulse: the group just completed equals PATTERN
- not_match  out  1  one-cycle pulse: the group just completed differs from PATTERN

Behaviour:
- Reset (rst_n=0, asynchronous):
  - bit counter cnt=0, shift register sh=0, match=0, not_match=0.
  - A partially received group is discarded.
  - The next group starts with the first edge after release.
- Every rising edge with rst_n=1 samples data as bit index cnt of the current group, with sh <= {sh[LEN-2:0], data}.
- cnt counts 0..LEN-1 and wraps to 0 after LEN-1. Groups never overlap; there is no resynchronisation on mismatch.
- On the edge where cnt==LEN-1:
  - word = {sh[LEN-2:0], data}
  - match <= (word==PATTERN)
  - not_match <= (word!=PATTERN)
- On every other edge: match <= 0, not_match <= 0.
- Outputs are registered and valid for exactly one cycle, starting at the edge that samples the group's last bit.
- Exactly one of match/not_match pulses per group. Never both; never either between group boundaries.
- Back-to-back groups yield a pulse every LEN cycles. Idle data (constant 0 or 1) still produces a not_match pulse every LEN cycles unless PATTERN is all-0 or all-1.
- Asynchronous reset mid-group clears the outputs immediately, including a pulse in progress.

Optional Feature:
- Macro: SEQ_DETECT_1_STATS_EN.
- With the macro defined, add outputs match_cnt[15:0] and mismatch_cnt[15:0]:
  - Each increments on the same edge its pulse is set.
  - Each saturates at 16'hFFFF.
  - Both clear to 0 on reset.
- Without the macro, the ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- Reset, release, then send 0,1,1,1,0,0 -> match=1 for one cycle at the 6th sampling edge; not_match stays 0.
- Immediately follow with 0,1,1,1,0,0 -> second match pulse exactly 6 cycles after the first; no not_match.
- Send 1,1,1,1,0,0 -> not_match=1 for one cycle at the 6th edge; match stays 0.
- Hold data=0 for 18 cycles -> three not_match pulses spaced 6 cycles apart; no match.
- Overlap/phase check: send 0,0,1,1,1,0,0 from the group start -> not_match at edge 6; embedded 011100 shifted by one bit is not detected.
- Assert rst_n=0 after 3 bits, then release and send 0,1,1,1,0,0 -> outputs 0 during reset; match at the 6th edge after release.
- With SEQ_DETECT_1_STATS_EN: sequence match, match, not_match -> match_cnt=2, mismatch_cnt=1; after reset both read 0.
